// File: rtl/mat_mul_engine.sv
// Square matrix multiplier: streams in A and B, computes R = A x B with one MAC, streams R out.
// Optional build macro MAT_MUL_SAT_EN saturates stored results instead of wrapping them.
module mat_mul_engine #(
    parameter int unsigned DIM_LOG    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    input  logic                    s00_axis_tvalid,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    input  logic                    sel,
    input  logic                    start,
    output logic                    busy,
    output logic                    load_err
);

    localparam int unsigned DIM       = 1 << DIM_LOG;
    localparam int unsigned SIZE      = DIM * DIM;
    localparam int unsigned SIZE_LOG  = 2 * DIM_LOG;
    localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + DIM_LOG;
    localparam int unsigned PH_W      = DIM_LOG + 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCalc   = 2'd1;
    localparam logic [1:0] StOutput = 2'd2;

    localparam logic [SIZE_LOG-1:0] LastIdx = SIZE_LOG'(SIZE - 1);
    localparam logic [SIZE_LOG-1:0] CntOne  = SIZE_LOG'(1);
    localparam logic [SIZE_LOG:0]   RdOne   = (SIZE_LOG + 1)'(1);
    localparam logic [PH_W-1:0]     PhOne   = PH_W'(1);
    localparam logic [PH_W-1:0]     PhLast  = PH_W'(DIM + 1);

    logic [DATA_WIDTH-1:0] mem_a [SIZE];
    logic [DATA_WIDTH-1:0] mem_b [SIZE];
    logic [DATA_WIDTH-1:0] mem_r [SIZE];

    logic [1:0]            state_q, state_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic                  load_err_q, load_err_d;
    logic [SIZE_LOG-1:0]   cnt_a_q, cnt_a_d;
    logic [SIZE_LOG-1:0]   cnt_b_q, cnt_b_d;
    logic [SIZE_LOG-1:0]   elem_q, elem_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [SIZE_LOG:0]     rd_idx_q, rd_idx_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

    logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;
    logic [SIZE_LOG-1:0]   a_addr, b_addr;
    logic [SIZE_LOG-1:0]   load_cnt, load_cnt_nxt;
    logic                  load_frame_err;
    logic                  beat;
    logic                  r_wr;
    logic                  out_fire;
    logic [DATA_WIDTH-1:0] out_word;

    logic                    a_sgn, b_sgn;
    logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [DATA_WIDTH-1:0]   res_val;

    assign s00_axis_tready = tready_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = '1;
    assign busy            = busy_q;
    assign load_err        = load_err_q;

    assign beat     = s00_axis_tvalid & tready_q & (state_q == StIdle);
    assign load_cnt = sel ? cnt_b_q : cnt_a_q;
    assign r_wr     = (state_q == StCalc) && (phase_q == PhLast);
    assign out_fire = tvalid_q & m00_axis_tready;
    assign out_word = mem_r[rd_idx_q[SIZE_LOG-1:0]];

    // Row i of A against column j of B; phase selects k during the read-issue cycles.
    assign a_addr = {elem_q[SIZE_LOG-1:DIM_LOG], phase_q[DIM_LOG-1:0]};
    assign b_addr = {phase_q[DIM_LOG-1:0], elem_q[DIM_LOG-1:0]};

    always_comb begin
        load_cnt_nxt   = load_cnt + CntOne;
        load_frame_err = 1'b0;
        if (s00_axis_tlast || (load_cnt == LastIdx)) begin
            load_cnt_nxt   = '0;
            load_frame_err = !(s00_axis_tlast && (load_cnt == LastIdx));
        end
    end

    // Low 2*DATA_WIDTH bits of the extended product are exact for both operand types.
    always_comb begin
        a_sgn    = (SIGNED != 0) && a_rd_q[DATA_WIDTH-1];
        b_sgn    = (SIGNED != 0) && b_rd_q[DATA_WIDTH-1];
        a_ext    = {{DATA_WIDTH{a_sgn}}, a_rd_q};
        b_ext    = {{DATA_WIDTH{b_sgn}}, b_rd_q};
        prod     = a_ext * b_ext;
        prod_ext = {{DIM_LOG{(SIGNED != 0) && prod[2*DATA_WIDTH-1]}}, prod};
    end

`ifdef MAT_MUL_SAT_EN
    always_comb begin
        res_val = acc_q[DATA_WIDTH-1:0];
        if (SIGNED != 0) begin
            if (!(&acc_q[ACC_WIDTH-1:DATA_WIDTH-1]) && (|acc_q[ACC_WIDTH-1:DATA_WIDTH-1])) begin
                res_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else if (|acc_q[ACC_WIDTH-1:DATA_WIDTH]) begin
            res_val = '1;
        end
    end
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_q[ACC_WIDTH-1:DATA_WIDTH];
    assign res_val       = acc_q[DATA_WIDTH-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        tready_d   = tready_q;
        busy_d     = busy_q;
        load_err_d = load_err_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        acc_d      = acc_q;
        rd_idx_d   = rd_idx_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;

        case (state_q)
            StIdle: begin
                tready_d = 1'b1;
                if (beat) begin
                    if (sel) begin
                        cnt_b_d = load_cnt_nxt;
                    end else begin
                        cnt_a_d = load_cnt_nxt;
                    end
                    if (load_frame_err) begin
                        load_err_d = 1'b1;
                    end
                end else if (start) begin
                    state_d    = StCalc;
                    tready_d   = 1'b0;
                    busy_d     = 1'b1;
                    load_err_d = 1'b0;
                    elem_d     = '0;
                    phase_d    = '0;
                end
            end

            StCalc: begin
                // Read data for k arrives one cycle after its address, so products span 1..DIM.
                if ((phase_q != '0) && (phase_q != PhLast)) begin
                    acc_d = (phase_q == PhOne) ? prod_ext : acc_q + prod_ext;
                end
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    if (elem_q == LastIdx) begin
                        elem_d   = '0;
                        rd_idx_d = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = StOutput;
                    end else begin
                        elem_d = elem_q + CntOne;
                    end
                end else begin
                    phase_d = phase_q + PhOne;
                end
            end

            StOutput: begin
                if (out_fire && tlast_q) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (!tvalid_q || m00_axis_tready) begin
                    // Refill the output register in the same cycle it drains.
                    if (!rd_idx_q[SIZE_LOG]) begin
                        tdata_d  = out_word;
                        tlast_d  = (rd_idx_q[SIZE_LOG-1:0] == LastIdx);
                        tvalid_d = 1'b1;
                        rd_idx_d = rd_idx_q + RdOne;
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q    <= StIdle;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            elem_q     <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            rd_idx_q   <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
            load_err_q <= load_err_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            elem_q     <= elem_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            rd_idx_q   <= rd_idx_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
        end
    end

    // Matrix storage survives reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (beat && !sel) begin
            mem_a[load_cnt] <= s00_axis_tdata;
        end
        if (beat && sel) begin
            mem_b[load_cnt] <= s00_axis_tdata;
        end
        if (r_wr) begin
            mem_r[elem_q] <= res_val;
        end
        a_rd_q <= mem_a[a_addr];
        b_rd_q <= mem_b[b_addr];
    end

endmodule

// File: tb/tb_mat_mul_engine.sv
// Directed bench for mat_mul_engine: three instances (2x2 unsigned, 4x4 unsigned, 2x2 signed).
module tb_mat_mul_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        sel;
    logic        m_tready;
    logic [2:0]  s_tvalid;
    logic [2:0]  start_v;
    logic [2:0]  s_tready;
    logic [2:0]  m_tvalid;
    logic [2:0]  m_tlast;
    logic [2:0]  busy;
    logic [2:0]  load_err;
    logic [31:0] m_tdata [3];
    logic [3:0]  m_tstrb [3];

    int cur;
    int errors;
    int checks;
    logic [31:0] vec [16];
    logic [31:0] expv [16];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mat_mul_engine #(
            .DIM_LOG    ((g == 1) ? 2 : 1),
            .DATA_WIDTH (32),
            .SIGNED     ((g == 2) ? 1 : 0)
        ) u_dut (
            .s00_axi_aclk    (clk),
            .s00_axi_aresetn (rst_n),
            .s00_axis_tready (s_tready[g]),
            .s00_axis_tdata  (s_tdata),
            .s00_axis_tlast  (s_tlast),
            .s00_axis_tvalid (s_tvalid[g]),
            .m00_axis_tvalid (m_tvalid[g]),
            .m00_axis_tdata  (m_tdata[g]),
            .m00_axis_tstrb  (m_tstrb[g]),
            .m00_axis_tlast  (m_tlast[g]),
            .m00_axis_tready (m_tready),
            .sel             (sel),
            .start           (start_v[g]),
            .busy            (busy[g]),
            .load_err        (load_err[g])
        );
    end

    task automatic load_mat(input logic s, input int n, input int last_at);
        int w;
        sel = s;
        for (int i = 0; i < n; i++) begin
            s_tdata = vec[i];
            s_tlast = (i == last_at);
            s_tvalid[cur] = 1'b1;
            w = 0;
            while (s_tready[cur] !== 1'b1 && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            checks++;
            if (w >= 20) begin
                errors++;
                $display("FAIL load_ready dut=%0d beat=%0d: tready=%b want 1", cur, i, s_tready[cur]);
            end
            @(posedge clk); #1;
        end
        s_tvalid[cur] = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic start_calc();
        start_v[cur] = 1'b1;
        @(posedge clk); #1;
        start_v[cur] = 1'b0;
        checks++;
        if (busy[cur] !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start dut=%0d: got %b want 1", cur, busy[cur]);
        end
    endtask

    task automatic run_output(input int n, input bit toggle, input string name);
        int beats = 0;
        int cyc = 0;
        int w;
        bit stall = 1'b0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        while (beats < n && cyc < 600) begin
            m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stall) begin
                checks++;
                if (m_tdata[cur] !== hd || m_tlast[cur] !== hl) begin
                    errors++;
                    $display("FAIL %s_stable: got %h/%b want %h/%b", name, m_tdata[cur], m_tlast[cur], hd, hl);
                end
            end
            checks++;
            if (busy[cur] !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy cyc=%0d: got %b want 1", name, cyc, busy[cur]);
            end
            if (m_tvalid[cur] === 1'b1 && m_tready) begin
                checks++;
                if (m_tdata[cur] !== expv[beats]) begin
                    errors++;
                    $display("FAIL %s_data[%0d]: got %h want %h", name, beats, m_tdata[cur], expv[beats]);
                end
                checks++;
                if (m_tlast[cur] !== (beats == n - 1)) begin
                    errors++;
                    $display("FAIL %s_tlast[%0d]: got %b want %b", name, beats, m_tlast[cur], beats == n - 1);
                end
                beats++;
            end
            stall = (m_tvalid[cur] === 1'b1) && !m_tready;
            hd = m_tdata[cur];
            hl = m_tlast[cur];
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (beats != n) begin
            errors++;
            $display("FAIL %s_beats: got %0d want %0d", name, beats, n);
        end
        m_tready = 1'b1;
        checks++;
        if (busy[cur] !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b want 0", name, busy[cur]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_tvalid[cur] !== 1'b0) begin
                errors++;
                $display("FAIL %s_extra_beat: tvalid=%b want 0", name, m_tvalid[cur]);
            end
            @(posedge clk); #1;
        end
        w = 0;
        while (s_tready[cur] !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (s_tready[cur] !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_tready: got %b want 1", name, s_tready[cur]);
        end
        m_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_tvalid = '0;
        start_v = '0;
        m_tready = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({s_tready[d], m_tvalid[d], m_tlast[d], busy[d], load_err[d]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl dut=%0d: got %b want 00000", d,
                         {s_tready[d], m_tvalid[d], m_tlast[d], busy[d], load_err[d]});
            end
            checks++;
            if (m_tdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_tdata dut=%0d: got %h want 0", d, m_tdata[d]);
            end
            checks++;
            if (m_tstrb[d] !== 4'hF) begin
                errors++;
                $display("FAIL tstrb dut=%0d: got %h want f", d, m_tstrb[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (s_tready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_tready dut=%0d: got %b want 1", d, s_tready[d]);
            end
        end
    endtask

    task automatic test_basic();
        cur = 0;
        vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
        load_mat(1'b0, 4, 3);
        vec[0] = 5; vec[1] = 6; vec[2] = 7; vec[3] = 8;
        load_mat(1'b1, 4, 3);
        start_calc();
        expv[0] = 19; expv[1] = 22; expv[2] = 43; expv[3] = 50;
        run_output(4, 1'b0, "basic");
    endtask

    task automatic test_wrap();
        cur = 0;
        vec[0] = 32'd65536; vec[1] = 0; vec[2] = 0; vec[3] = 0;
        load_mat(1'b0, 4, 3);
        load_mat(1'b1, 4, 3);
        start_calc();
`ifdef MAT_MUL_SAT_EN
        expv[0] = 32'hFFFF_FFFF;
`else
        expv[0] = 32'h0000_0000;
`endif
        expv[1] = 0; expv[2] = 0; expv[3] = 0;
        run_output(4, 1'b0, "wrap");
    endtask

    task automatic test_load_err();
        cur = 0;
        vec[0] = 9; vec[1] = 9;
        load_mat(1'b0, 2, 1);
        checks++;
        if (load_err[cur] !== 1'b1) begin
            errors++;
            $display("FAIL load_err_set: got %b want 1", load_err[cur]);
        end
        vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
        load_mat(1'b0, 4, 3);
        vec[0] = 5; vec[1] = 6; vec[2] = 7; vec[3] = 8;
        load_mat(1'b1, 4, 3);
        checks++;
        if (load_err[cur] !== 1'b1) begin
            errors++;
            $display("FAIL load_err_sticky: got %b want 1", load_err[cur]);
        end
        start_calc();
        checks++;
        if (load_err[cur] !== 1'b0) begin
            errors++;
            $display("FAIL load_err_clear: got %b want 0", load_err[cur]);
        end
        expv[0] = 19; expv[1] = 22; expv[2] = 43; expv[3] = 50;
        run_output(4, 1'b0, "reload");
    endtask

    task automatic test_signed();
        cur = 2;
        vec[0] = 32'hFFFF_FFFF; vec[1] = 2; vec[2] = 3; vec[3] = 32'hFFFF_FFFC;
        load_mat(1'b0, 4, 3);
        vec[0] = 5; vec[1] = 32'hFFFF_FFFA; vec[2] = 7; vec[3] = 8;
        load_mat(1'b1, 4, 3);
        start_calc();
        expv[0] = 32'h0000_0009; expv[1] = 32'h0000_0016;
        expv[2] = 32'hFFFF_FFF3; expv[3] = 32'hFFFF_FFCE;
        run_output(4, 1'b0, "signed");
    endtask

    task automatic test_stall();
        cur = 1;
        for (int i = 0; i < 16; i++) vec[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
        load_mat(1'b0, 16, 15);
        for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
        load_mat(1'b1, 16, 15);
        start_calc();
        for (int i = 0; i < 16; i++) expv[i] = 32'(i + 1);
        run_output(16, 1'b1, "stall");
    endtask

    task automatic test_reset_mid_calc();
        cur = 1;
        for (int i = 0; i < 16; i++) vec[i] = 32'(3 * i);
        load_mat(1'b0, 16, 15);
        load_mat(1'b1, 16, 15);
        start_calc();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (m_tvalid[cur] !== 1'b0 || busy[cur] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: tvalid=%b busy=%b want 0 0", m_tvalid[cur], busy[cur]);
        end
        @(posedge clk); #1;
        checks++;
        if (s_tready[cur] !== 1'b1) begin
            errors++;
            $display("FAIL abort_tready: got %b want 1", s_tready[cur]);
        end
        for (int i = 0; i < 16; i++) vec[i] = (i % 5 == 0) ? 32'd2 : 32'd0;
        load_mat(1'b0, 16, 15);
        for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
        load_mat(1'b1, 16, 15);
        start_calc();
        for (int i = 0; i < 16; i++) expv[i] = 32'(2 * (i + 1));
        run_output(16, 1'b0, "after_abort");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cur = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_load_err();
        test_signed();
        test_stall();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
